mda_motor_pwm_gen: RTL and testbench

Upstream driver for the per-motor H-bridge output stage. It converts a signed duty command from the control/bus side into the registered {dir, on} pair that the output stage consumes. It produces fixed-period PWM with a one-deep command buffer and period-boundary updates. It enforces a coast period on direction reversal and a command watchdog so a stalled controller cannot leave a thruster running.

---
 rtl/mda_motor_pwm_gen_if.sv | 17 +
 rtl/mda_motor_pwm_gen.sv | 168 ++++++++++++++++
 tb/tb_mda_motor_pwm_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mda_motor_pwm_gen_if.sv
// rtl/mda_motor_pwm_gen_if.sv - duty command handshake bundle for mda_motor_pwm_gen
//
// Purpose: carries one signed duty command from the control side to the PWM generator.
// Signals:
//   cmd_valid  master->slave  a command is presented on cmd_duty
//   cmd_ready  slave->master  the generator can accept a command this cycle
//   cmd_duty   master->slave  DUTY_W+1 bit two's complement duty (>0 fwd, <0 rev, 0 coast)
interface mda_motor_pwm_gen_if #(
  parameter int DUTY_W = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W:0]   cmd_duty;

  modport master (output cmd_valid, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/mda_motor_pwm_gen.sv
// rtl/mda_motor_pwm_gen.sv - signed-duty PWM generator with reversal coast and command watchdog
//
// Purpose: turns a signed duty command into the registered {dir, on} pair for one
// H-bridge, with a one-deep command buffer applied only at PWM period boundaries.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   cmd           command handshake (slave side): cmd_valid / cmd_ready / cmd_duty
//   dir           direction to output stage, 1 = reverse
//   on            drive enable to output stage
//   period_start  one-cycle pulse on the first output cycle of each period
//   timeout       watchdog tripped; held until the next command takes effect
module mda_motor_pwm_gen #(
  parameter int PERIOD       = 1000,
  parameter int DUTY_W       = 10,
  parameter int WDOG_PERIODS = 5000
) (
  input  logic               clk,
  input  logic               reset,
  mda_motor_pwm_gen_if.slave cmd,
  output logic               dir,
  output logic               on,
  output logic               period_start,
  output logic               timeout
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int WW = $clog2(WDOG_PERIODS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0]   MAG_MAX  = CW'(PERIOD);
  localparam logic [WW-1:0]   WD_LAST  = WW'(WDOG_PERIODS - 1);
  localparam logic [DUTY_W:0] ONE      = 1;

  typedef enum logic [1:0] {S_RUN, S_COAST, S_TIMEOUT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            pend_full;
  logic [DUTY_W:0] pend_duty;
  logic [CW-1:0]   mag_act, mag_n;
  logic            dir_act, dir_act_n;
  logic            last_dir, last_dir_n;
  logic [WW-1:0]   wdog, wdog_n;
  logic            acc_seen, acc_seen_n;
  logic            timeout_n;
  logic            pend_clear;

  logic            boundary;
  logic            accept;
  logic            acc_period;
  logic            pend_sign;
  logic [DUTY_W:0] pend_abs;
  logic [CW-1:0]   pend_mag;

  assign boundary      = (cnt == CNT_LAST);
  assign cmd.cmd_ready = !pend_full || boundary;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  // An accept in the boundary cycle still belongs to the period that is ending.
  assign acc_period    = acc_seen || accept;

  // Magnitude conversion; the unsigned view of the negated most-negative code is
  // exactly 2^DUTY_W, so it needs no special case before saturation.
  assign pend_sign = pend_duty[DUTY_W];
  assign pend_abs  = pend_sign ? (~pend_duty + ONE) : pend_duty;
  assign pend_mag  = (32'(pend_abs) > 32'(PERIOD)) ? MAG_MAX : CW'(pend_abs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    mag_n      = mag_act;
    dir_act_n  = dir_act;
    last_dir_n = last_dir;
    wdog_n     = wdog;
    timeout_n  = timeout;
    pend_clear = 1'b0;
    acc_seen_n = acc_period;
    if (boundary) begin
      acc_seen_n = 1'b0;
      if (acc_period)            wdog_n = '0;
      else if (wdog != WD_LAST)  wdog_n = wdog + WW'(1);

      if (!acc_period && (wdog == WD_LAST)) begin
        state_n    = S_TIMEOUT;
        mag_n      = '0;
        pend_clear = 1'b1;
        timeout_n  = 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (pend_full) begin
              if ((pend_mag != '0) && (pend_sign != last_dir) && (mag_act != '0)) begin
                // Reversal while driving: stop for one period, keep the command pending.
                state_n = S_COAST;
                mag_n   = '0;
              end else begin
                mag_n      = pend_mag;
                dir_act_n  = pend_sign;
                pend_clear = 1'b1;
                if (pend_mag != '0) last_dir_n = pend_sign;
              end
            end
          end
          S_COAST: begin
            state_n = S_RUN;
            if (pend_full) begin
              mag_n      = pend_mag;
              dir_act_n  = pend_sign;
              pend_clear = 1'b1;
              if (pend_mag != '0) last_dir_n = pend_sign;
            end
          end
          S_TIMEOUT: begin
            // Motor is already stopped, so a reversal needs no coast here.
            if (pend_full) begin
              state_n    = S_RUN;
              mag_n      = pend_mag;
              dir_act_n  = pend_sign;
              last_dir_n = pend_sign;
              pend_clear = 1'b1;
              timeout_n  = 1'b0;
            end
          end
          default: state_n = S_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      pend_full    <= 1'b0;
      pend_duty    <= '0;
      mag_act      <= '0;
      dir_act      <= 1'b0;
      last_dir     <= 1'b0;
      wdog         <= '0;
      acc_seen     <= 1'b0;
      timeout      <= 1'b0;
      on           <= 1'b0;
      dir          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt <= boundary ? '0 : cnt + CW'(1);
      // A boundary accept overwrites the slot freed (or still held) on the same edge.
      if (accept) begin
        pend_duty <= cmd.cmd_duty;
        pend_full <= 1'b1;
      end else if (pend_clear) begin
        pend_full <= 1'b0;
      end
      mag_act      <= mag_n;
      dir_act      <= dir_act_n;
      last_dir     <= last_dir_n;
      wdog         <= wdog_n;
      acc_seen     <= acc_seen_n;
      timeout      <= timeout_n;
      on           <= (state == S_RUN) && (cnt < mag_act);
      dir          <= (state == S_RUN) && (mag_act != '0) && dir_act;
      period_start <= (cnt == '0);
    end
  end

endmodule

// File: tb/tb_mda_motor_pwm_gen.sv
// tb/tb_mda_motor_pwm_gen.sv - self-checking bench for mda_motor_pwm_gen
module tb_mda_motor_pwm_gen;
  localparam int P  = 8;
  localparam int DW = 10;
  localparam int WD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dir, on, period_start, timeout;

  mda_motor_pwm_gen_if #(.DUTY_W(DW)) cmd_if ();

  mda_motor_pwm_gen #(.PERIOD(P), .DUTY_W(DW), .WDOG_PERIODS(WD)) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if),
    .dir(dir), .on(on), .period_start(period_start), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          win;
    logic [23:0] pat;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          win_no = 0;
  int          ph = 7;
  bit          locked = 1'b0;
  logic [7:0]  w_on, w_dir, w_to;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
  endtask

  // {on bits, dir bits, timeout bits}; bit i = output cycle i of the period.
  function automatic logic [23:0] pat(int k, bit d, logic [7:0] to);
    logic [8:0] m;
    m = (9'd1 << k) - 9'd1;
    return {m[7:0], (d && k != 0) ? 8'hFF : 8'h00, to};
  endfunction

  task automatic push(int w, int k, bit d, logic [7:0] to, string tag);
    exp_t e;
    e.win = w;
    e.pat = pat(k, d, to);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic score_window();
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].win < win_no) begin
      e = exp_q.pop_front();
      chk({e.tag, "_window_seen"}, 32'(win_no), 32'(e.win));
    end
    if (exp_q.size() > 0 && exp_q[0].win == win_no) begin
      e = exp_q.pop_front();
      chk(e.tag, {8'h00, w_on, w_dir, w_to}, {8'h00, e.pat});
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      locked = 1'b0;
      ph = 7;
    end else if (period_start) begin
      win_no++;
      ph = 0;
      locked = 1'b1;
      w_on[0] = on; w_dir[0] = dir; w_to[0] = timeout;
    end else if (locked && ph < 7) begin
      ph++;
      w_on[ph] = on; w_dir[ph] = dir; w_to[ph] = timeout;
      if (ph == 7) score_window();
    end
  end

  function automatic int cur_idx();
    return (ph + 1) % 8;
  endfunction

  function automatic int cur_win();
    return (ph == 7) ? win_no + 1 : win_no;
  endfunction

  task automatic goto_win(int w, int i);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (locked && cur_win() == w && cur_idx() == i) return;
    end
    n_total++;
    $error("FAIL goto_win no cycle %0d of window %0d within budget, at window %0d", i, w, cur_win());
  endtask

  task automatic send(logic [DW:0] d, output bit acc);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = d;
    acc = cmd_if.cmd_ready;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  w;
    bit  a;
    bit  first_ready;
    bit  r;
    int  acc_idx;
    int  i;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_duty  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_on", 32'(on), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_period_start", 32'(period_start), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
    @(posedge clk); #1;
    chk("rst_first_period_start", 32'(period_start), 1);

    // Basic forward duty.
    goto_win(1, 1);
    w = cur_win();
    send(11'd3, a);
    chk("t1_accept", 32'(a), 1);
    push(w,     0, 0, 8'h00, "t1_idle");
    push(w + 1, 3, 0, 8'h00, "t1_fwd3_a");
    push(w + 2, 3, 0, 8'h00, "t1_fwd3_b");

    // Saturation forward, then most-negative code with reversal coast.
    goto_win(w + 2, 1);
    send(11'd200, a);
    push(w + 3, 8, 0, 8'h00, "t2_full_fwd");
    goto_win(w + 3, 1);
    send(11'h400, a);
    push(w + 4, 0, 0, 8'h00, "t2_coast");
    push(w + 5, 8, 1, 8'h00, "t2_full_rev");

    // Reversal both ways with coast.
    goto_win(w + 5, 1);
    send(11'd3, a);
    push(w + 6, 0, 0, 8'h00, "t3_coast_to_fwd");
    push(w + 7, 3, 0, 8'h00, "t3_fwd3");
    goto_win(w + 7, 1);
    send(11'h7FB, a);
    push(w + 8, 0, 0, 8'h00, "t3_coast_to_rev");
    push(w + 9, 5, 1, 8'h00, "t3_rev5");

    // Back-to-back commands: second waits for the boundary cycle.
    goto_win(w + 9, 1);
    send(11'd0, a);
    push(w + 10, 0, 0, 8'h00, "t4_zero");
    goto_win(w + 10, 1);
    send(11'd2, a);
    chk("t4_accept_first", 32'(a), 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_duty  = 11'd6;
    first_ready = cmd_if.cmd_ready;
    acc_idx = -1;
    for (int n = 0; n < 10; n++) begin
      i = cur_idx();
      r = cmd_if.cmd_ready;
      @(posedge clk); #1;
      if (r) begin
        acc_idx = i;
        break;
      end
    end
    cmd_if.cmd_valid = 1'b0;
    chk("t4_busy_ready", 32'(first_ready), 0);
    chk("t4_accept_cycle", 32'(acc_idx), 6);
    push(w + 11, 2, 0, 8'h00, "t4_two");
    push(w + 12, 6, 0, 8'h00, "t4_six");

    // Watchdog trip and recovery without coast.
    goto_win(w + 12, 1);
    send(11'd4, a);
    push(w + 13, 4, 0, 8'h00, "t5_run_a");
    push(w + 14, 4, 0, 8'h00, "t5_run_b");
    push(w + 15, 4, 0, 8'h00, "t5_run_c");
    push(w + 16, 4, 0, 8'h80, "t5_trip");
    push(w + 17, 0, 0, 8'hFF, "t5_timeout");
    goto_win(w + 18, 1);
    send(11'd1, a);
    chk("t5_accept_in_timeout", 32'(a), 1);
    push(w + 18, 0, 0, 8'h7F, "t5_clear");
    push(w + 19, 1, 0, 8'h00, "t5_resume");

    // Reset in the middle of a driven period.
    goto_win(w + 19, 1);
    send(11'd6, a);
    goto_win(w + 20, 4);
    chk("t6_on_before_reset", 32'(on), 1);
    reset = 1'b1;
    #1;
    chk("t6_on_in_reset", 32'(on), 0);
    chk("t6_dir_in_reset", 32'(dir), 0);
    chk("t6_timeout_in_reset", 32'(timeout), 0);
    chk("t6_scoreboard_drained", 32'(exp_q.size()), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_ready_after_release", 32'(cmd_if.cmd_ready), 1);
    chk("t6_no_period_start_yet", 32'(period_start), 0);
    @(posedge clk); #1;
    chk("t6_period_start_after_release", 32'(period_start), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
